// File: rtl/fqmul_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fqmul_rr_scheduler_pkg
//   Shared constants and types for the fqmul round-robin scheduler.
//   Q / MONT      : Dilithium modulus and Montgomery constant (2^32 mod Q, signed)
//   DEF_WIDTH     : default operand/result width
//   state_t       : scheduler FSM encoding
//   idx_width()   : lane-index width for a given requester count
// -----------------------------------------------------------------------------
package fqmul_rr_scheduler_pkg;

   localparam int Q         = 8380417;
   localparam int MONT      = -4186625;
   localparam int DEF_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ABORT = 3'd4
   } state_t;

   // At least one bit even for degenerate counts so index vectors stay legal.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fqmul_rr_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// fqmul_rr_scheduler_rr_pick
//   Combinational round-robin picker: finds the first set request bit starting
//   at ptr and searching upward, wrapping past the last lane.
//   Ports:
//     req_i     N_REQ request vector
//     ptr_i     lane the search starts from (must be < N_REQ)
//     valid_o   some request is set
//     idx_o     index of the chosen lane
//     onehot_o  one-hot form of idx_o (zero when valid_o is low)
// -----------------------------------------------------------------------------
module fqmul_rr_scheduler_rr_pick
   import fqmul_rr_scheduler_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [N_REQ-1:0] onehot_o
);

   // Lane that is k positions after ptr, modulo N_REQ.
   function automatic logic [IDX_W-1:0] lane_at(input logic [IDX_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return IDX_W'(s);
   endfunction

   // Scan from the farthest lane back toward ptr so the closest hit wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_i[lane_at(ptr_i, k)]) begin
            valid_o = 1'b1;
            idx_o   = lane_at(ptr_i, k);
         end
      end
   end

   always_comb begin
      onehot_o = '0;
      if (valid_o) onehot_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/fqmul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fqmul_rr_scheduler
//   Shares one external fqmul multiplier among N_REQ requesters in round-robin
//   order, one transaction at a time, with a watchdog that aborts and resets a
//   multiplier that never reports done.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     req_i           per-lane request, held with operands until own done
//     op_a_i, op_b_i  packed signed operands, lane i = [i*WIDTH +: WIDTH]
//     gnt_o           one-hot grant, ISSUE through RESP/ABORT
//     done_o          one-cycle pulse to the granted lane, result_o valid then
//     result_o        registered product, held until the next completion
//     err_o           one-cycle pulse to the granted lane on watchdog abort
//     busy_o          FSM not idle
//     mul_start_o     one-cycle start pulse to the multiplier
//     mul_a_o/mul_b_o latched operands to the multiplier
//     mul_reset_o     active-high synchronous reset to the multiplier
//     mul_done_i      multiplier done
//     mul_reduce_i    multiplier result, taken only on mul_done_i in WAIT
// -----------------------------------------------------------------------------
module fqmul_rr_scheduler
   import fqmul_rr_scheduler_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] op_a_i,
   input  logic [N_REQ*WIDTH-1:0] op_b_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic [N_REQ-1:0]       done_o,
   output logic [WIDTH-1:0]       result_o,
   output logic [N_REQ-1:0]       err_o,
   output logic                   busy_o,
   output logic                   mul_start_o,
   output logic [WIDTH-1:0]       mul_a_o,
   output logic [WIDTH-1:0]       mul_b_o,
   output logic                   mul_reset_o,
   input  logic                   mul_done_i,
   input  logic [WIDTH-1:0]       mul_reduce_i
);

   localparam int IDX_W  = idx_width(N_REQ);
   localparam int WDOG_W = $clog2(TIMEOUT);

   state_t                   state_q;
   logic [IDX_W-1:0]         ptr_q;
   logic [IDX_W-1:0]         idx_q;
   logic [N_REQ-1:0]         gnt_q;
   logic [N_REQ-1:0]         done_q;
   logic [N_REQ-1:0]         err_q;
   logic                     start_q;
   logic                     mul_reset_q;
   logic signed [WIDTH-1:0]  result_q;
   logic signed [WIDTH-1:0]  mul_a_q;
   logic signed [WIDTH-1:0]  mul_b_q;
   logic [WDOG_W-1:0]        wdog_q;

   logic [IDX_W-1:0]         ptr_d;
   logic [WDOG_W-1:0]        wdog_d;
   logic                     wdog_expired;

   logic                     pick_vld;
   logic [IDX_W-1:0]         pick_idx;
   logic [N_REQ-1:0]         pick_oh;

   fqmul_rr_scheduler_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .valid_o  (pick_vld),
      .idx_o    (pick_idx),
      .onehot_o (pick_oh)
   );

   // Pointer moves to the lane after the one just served, so a lane that keeps
   // requesting cannot starve the others.
   assign ptr_d        = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
   assign wdog_d       = wdog_q + 1'b1;
   assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT - 1));

   // Pulse outputs default low every cycle; each state raises what it owns.
   // mul_reset is held high through reset and falls on the first edge after.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         idx_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= '0;
         start_q     <= 1'b0;
         mul_reset_q <= 1'b1;
         result_q    <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         wdog_q      <= '0;
      end else begin
         start_q     <= 1'b0;
         done_q      <= '0;
         err_q       <= '0;
         mul_reset_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  idx_q   <= pick_idx;
                  gnt_q   <= pick_oh;
                  mul_a_q <= op_a_i[pick_idx*WIDTH +: WIDTH];
                  mul_b_q <= op_b_i[pick_idx*WIDTH +: WIDTH];
                  start_q <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            // A done seen here belongs to nothing we issued, so it is ignored.
            ST_ISSUE: begin
               wdog_q  <= '0;
               state_q <= ST_WAIT;
            end
            // Done is checked before the watchdog so a result arriving on the
            // last allowed cycle is still delivered.
            ST_WAIT: begin
               if (mul_done_i) begin
                  result_q <= mul_reduce_i;
                  done_q   <= gnt_q;
                  state_q  <= ST_RESP;
               end else if (wdog_expired) begin
                  err_q       <= gnt_q;
                  mul_reset_q <= 1'b1;
                  state_q     <= ST_ABORT;
               end else begin
                  wdog_q <= wdog_d;
               end
            end
            ST_RESP, ST_ABORT: begin
               ptr_q   <= ptr_d;
               gnt_q   <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               gnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign result_o    = result_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign mul_start_o = start_q;
   assign mul_a_o     = mul_a_q;
   assign mul_b_o     = mul_b_q;
   assign mul_reset_o = mul_reset_q;

endmodule

// File: tb/tb_fqmul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fqmul_rr_scheduler
//   Directed bench for fqmul_rr_scheduler with a behavioural Montgomery
//   multiplier (programmable latency, optional hang) on the mul_* side.
// -----------------------------------------------------------------------------
module tb_fqmul_rr_scheduler;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int T   = 16;
   localparam longint QL    = 64'sd8380417;
   localparam longint QINV  = 64'sd58728449;
   localparam int     MONTC = -4186625;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] op_a, op_b;
   logic [N-1:0]   gnt, done, err;
   logic [W-1:0]   result;
   logic           busy, mul_start, mul_reset;
   logic [W-1:0]   mul_a, mul_b;
   logic           mdone = 1'b0;
   logic [W-1:0]   mred  = '0;

   int vectors = 0;
   int errors  = 0;

   // multiplier model state
   bit  hang = 1'b0;
   int  mlat = 3;
   bit  mbusy = 1'b0;
   int  mcnt = 0;
   logic signed [W-1:0] ma = '0, mb = '0;

   always #5 clk = ~clk;

   fqmul_rr_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .op_a_i       (op_a),
      .op_b_i       (op_b),
      .gnt_o        (gnt),
      .done_o       (done),
      .result_o     (result),
      .err_o        (err),
      .busy_o       (busy),
      .mul_start_o  (mul_start),
      .mul_a_o      (mul_a),
      .mul_b_o      (mul_b),
      .mul_reset_o  (mul_reset),
      .mul_done_i   (mdone),
      .mul_reduce_i (mred)
   );

   // Dilithium montgomery_reduce: a * 2^-32 mod Q, result in (-Q, Q).
   function automatic logic [W-1:0] mont(input longint a);
      longint t, r;
      int     t32;
      t   = a * QINV;
      t32 = int'(t);
      r   = (a - longint'(t32) * QL) >>> 32;
      return r[W-1:0];
   endfunction

   function automatic longint modq(input logic [W-1:0] x);
      longint v;
      v = longint'($signed(x)) % QL;
      if (v < 0) v = v + QL;
      return v;
   endfunction

   // Done appears mlat cycles after the cycle in which start is high.
   always @(posedge clk) begin
      mdone <= 1'b0;
      if (mul_reset) begin
         mbusy <= 1'b0;
      end else if (mul_start) begin
         mbusy <= 1'b1;
         mcnt  <= 1;
         ma    <= $signed(mul_a);
         mb    <= $signed(mul_b);
      end else if (mbusy) begin
         if (mcnt == mlat - 1 && !hang) begin
            mdone <= 1'b1;
            mred  <= mont(longint'(ma) * longint'(mb));
            mbusy <= 1'b0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mul_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_resp(input int limit, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < limit; i++) begin
         step();
         n++;
         if (done !== '0 || err !== '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_lane(input int l, input int a, input int b);
      op_a[l*W +: W] = a;
      op_b[l*W +: W] = b;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = '0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) step();
      vectors++;
      if (gnt !== '0 || done !== '0 || err !== '0 || busy !== 1'b0 || mul_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b start=%b, want all 0", gnt, done, err, busy, mul_start);
      end
      vectors++;
      if (result !== '0 || mul_a !== '0 || mul_b !== '0) begin
         errors++;
         $display("FAIL reset_data: result=%h mul_a=%h mul_b=%h, want 0", result, mul_a, mul_b);
      end
      vectors++;
      if (mul_reset !== 1'b1) begin
         errors++;
         $display("FAIL reset_mulreset: got %b want 1", mul_reset);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (mul_reset !== 1'b1) begin
         errors++;
         $display("FAIL mulreset_before_edge: got %b want 1", mul_reset);
      end
      step();
      vectors++;
      if (mul_reset !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mulreset_release: mul_reset=%b busy=%b want 0 0", mul_reset, busy);
      end
   endtask

   task automatic test_single_op();
      bit ok;
      int n;
      set_lane(0, 1234, MONTC);
      req = 4'b0001;
      step();
      vectors++;
      if (mul_start !== 1'b1 || gnt !== 4'b0001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_issue: start=%b gnt=%b busy=%b want 1 0001 1", mul_start, gnt, busy);
      end
      vectors++;
      if (mul_a !== 32'd1234 || mul_b !== 32'(MONTC)) begin
         errors++;
         $display("FAIL single_operands: a=%0d b=%0d want 1234 %0d", $signed(mul_a), $signed(mul_b), MONTC);
      end
      step();
      vectors++;
      if (mul_start !== 1'b0 || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL single_wait: start=%b gnt=%b want 0 0001", mul_start, gnt);
      end
      wait_resp(20, n, ok);
      vectors++;
      if (!ok || done !== 4'b0001 || err !== '0) begin
         errors++;
         $display("FAIL single_done: ok=%b done=%b err=%b want 1 0001 0000", ok, done, err);
      end
      vectors++;
      if (modq(result) !== 64'd1234) begin
         errors++;
         $display("FAIL single_result: got %0d mod Q want 1234", modq(result));
      end
      req = '0;
      step();
      vectors++;
      if (gnt !== '0 || busy !== 1'b0 || done !== '0 || modq(result) !== 64'd1234) begin
         errors++;
         $display("FAIL single_idle: gnt=%b busy=%b done=%b res=%0d want 0000 0 0000 1234", gnt, busy, done, modq(result));
      end
   endtask

   task automatic test_contention();
      bit ok;
      int n;
      logic [N-1:0] seen, expg;
      apply_reset();
      for (int i = 0; i < N; i++) set_lane(i, i + 10, MONTC);
      seen = '0;
      req  = 4'b1111;
      for (int k = 0; k < N; k++) begin
         expg = 4'b0001 << k;
         wait_start(ok);
         vectors++;
         if (!ok || gnt !== expg) begin
            errors++;
            $display("FAIL contention_grant%0d: ok=%b gnt=%b want %b", k, ok, gnt, expg);
         end
         vectors++;
         if ((seen & gnt) !== '0) begin
            errors++;
            $display("FAIL contention_regrant%0d: gnt=%b already served %b", k, gnt, seen);
         end
         seen = seen | gnt;
         wait_resp(20, n, ok);
         vectors++;
         if (!ok || done !== expg || modq(result) !== longint'(k + 10)) begin
            errors++;
            $display("FAIL contention_done%0d: done=%b res=%0d want %b %0d", k, done, modq(result), expg, k + 10);
         end
         req[k] = 1'b0;
      end
      step();
   endtask

   task automatic test_wrap();
      bit ok;
      int n;
      int lanes [3] = '{0, 3, 0};
      int vals  [3] = '{100, 300, 100};
      logic [N-1:0] expg;
      set_lane(3, 300, MONTC);
      set_lane(0, 100, MONTC);
      req = 4'b1000;
      wait_start(ok);
      vectors++;
      if (!ok || gnt !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_lane3: ok=%b gnt=%b want 1000", ok, gnt);
      end
      wait_resp(20, n, ok);
      req = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         expg = 4'b0001 << lanes[k];
         wait_start(ok);
         vectors++;
         if (!ok || gnt !== expg) begin
            errors++;
            $display("FAIL wrap_grant%0d: ok=%b gnt=%b want %b", k, ok, gnt, expg);
         end
         wait_resp(20, n, ok);
         vectors++;
         if (!ok || done !== expg || modq(result) !== longint'(vals[k])) begin
            errors++;
            $display("FAIL wrap_done%0d: done=%b res=%0d want %b %0d", k, done, modq(result), expg, vals[k]);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_watchdog();
      bit ok;
      int n;
      hang = 1'b1;
      set_lane(2, 55, MONTC);
      req = 4'b0100;
      wait_start(ok);
      wait_resp(T + 10, n, ok);
      vectors++;
      if (!ok || n != T + 1) begin
         errors++;
         $display("FAIL wdog_timing: ok=%b cycles=%0d want %0d", ok, n, T + 1);
      end
      vectors++;
      if (err !== 4'b0100 || mul_reset !== 1'b1 || done !== '0) begin
         errors++;
         $display("FAIL wdog_abort: err=%b mul_reset=%b done=%b want 0100 1 0000", err, mul_reset, done);
      end
      vectors++;
      if (modq(result) !== 64'd100) begin
         errors++;
         $display("FAIL wdog_result: got %0d want 100", modq(result));
      end
      req = '0;
      step();
      vectors++;
      if (err !== '0 || mul_reset !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wdog_idle: err=%b mul_reset=%b busy=%b want 0000 0 0", err, mul_reset, busy);
      end
      hang = 1'b0;
   endtask

   task automatic test_done_at_timeout();
      bit ok;
      int n;
      mlat = T;
      set_lane(0, 77, MONTC);
      req = 4'b0001;
      wait_start(ok);
      wait_resp(T + 10, n, ok);
      vectors++;
      if (!ok || done !== 4'b0001 || err !== '0 || n != T + 1) begin
         errors++;
         $display("FAIL done_vs_timeout: done=%b err=%b cycles=%0d want 0001 0000 %0d", done, err, n, T + 1);
      end
      vectors++;
      if (modq(result) !== 64'd77) begin
         errors++;
         $display("FAIL done_vs_timeout_result: got %0d want 77", modq(result));
      end
      req  = '0;
      mlat = 3;
      step();
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      int n;
      logic [N-1:0] pulses;
      hang = 1'b1;
      set_lane(0, 5, MONTC);
      req = 4'b0001;
      wait_start(ok);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (gnt !== '0 || busy !== 1'b0 || mul_reset !== 1'b1 || mul_start !== 1'b0) begin
         errors++;
         $display("FAIL rstwait_ctrl: gnt=%b busy=%b mul_reset=%b start=%b want 0000 0 1 0", gnt, busy, mul_reset, mul_start);
      end
      vectors++;
      if (mul_a !== '0 || result !== '0 || done !== '0 || err !== '0) begin
         errors++;
         $display("FAIL rstwait_data: mul_a=%h result=%h done=%b err=%b want 0", mul_a, result, done, err);
      end
      pulses = '0;
      repeat (2) begin
         step();
         pulses = pulses | done | err;
      end
      rst_n = 1'b1;
      hang  = 1'b0;
      set_lane(0, 9, MONTC);
      wait_start(ok);
      vectors++;
      if (pulses !== '0 || !ok || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL rstwait_regrant: pulses=%b ok=%b gnt=%b want 0000 1 0001", pulses, ok, gnt);
      end
      wait_resp(20, n, ok);
      vectors++;
      if (!ok || done !== 4'b0001 || modq(result) !== 64'd9) begin
         errors++;
         $display("FAIL rstwait_done: done=%b res=%0d want 0001 9", done, modq(result));
      end
      req = '0;
      step();
   endtask

   task automatic test_req_drop();
      bit ok;
      int n;
      int extra;
      set_lane(1, 21, MONTC);
      req = 4'b0010;
      wait_start(ok);
      vectors++;
      if (!ok || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL drop_grant: ok=%b gnt=%b want 0010", ok, gnt);
      end
      req = '0;
      set_lane(1, 999, MONTC);
      wait_resp(20, n, ok);
      vectors++;
      if (!ok || done !== 4'b0010 || modq(result) !== 64'd21) begin
         errors++;
         $display("FAIL drop_done: done=%b res=%0d want 0010 21", done, modq(result));
      end
      extra = 0;
      repeat (8) begin
         step();
         if (gnt !== '0 || mul_start !== 1'b0) extra++;
      end
      vectors++;
      if (extra != 0) begin
         errors++;
         $display("FAIL drop_regrant: %0d cycles with grant/start, want 0", extra);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_contention();
      test_wrap();
      test_watchdog();
      test_done_at_timeout();
      test_reset_in_wait();
      test_req_drop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, got running want finished");
      $fatal(1, "timeout");
   end

endmodule
